// File: rtl/gate_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : gate_scheduler
//  Description : Shares one parking gate between the entry lane and queued
//                exit requests. Each passage runs grant -> event pulse to the
//                parking FSM -> gate hold -> close guard cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_scheduler #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [1:0] exit_req_slot,
    input  logic [3:0] spots,
    input  logic       is_full,
    output logic       entry_signal,
    output logic       exit_signal,
    output logic [1:0] exit_slot,
    output logic       gate_open,
    output logic       busy,
    output logic       exit_err
);

    localparam int                c_cnt_w     = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_OPEN  = 2'd2,
        S_CLOSE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_entry_q;
    logic                 r_entry_armed;
    logic [3:0]           r_pending;
    logic                 r_last_entry;     // 1: last grant was entry, 0: exit
    logic [c_cnt_w-1:0]   r_hold_cnt;

    logic                 w_entry_rise;
    logic                 w_entry_elig;
    logic                 w_exit_elig;
    logic [1:0]           w_low_slot;
    logic                 w_grant_entry;
    logic                 w_grant_exit;
    logic                 w_exit_accept;
    logic                 w_clr_entry;
    logic [3:0]           w_clr_mask;
    logic [3:0]           w_set_mask;

    assign w_entry_rise = entry_req & ~r_entry_q;
    assign w_entry_elig = (r_entry_armed | w_entry_rise) & ~is_full;
    assign w_exit_elig  = |r_pending;

    // The granted request is retired at the end of ISSUE, so a same-slot
    // request arriving during ISSUE still sees its bit pending and is refused.
    assign w_clr_entry  = (r_state == S_ISSUE) & entry_signal;
    assign w_clr_mask   = ((r_state == S_ISSUE) && exit_signal) ? (4'b0001 << exit_slot) : 4'b0000;

    assign w_exit_accept = exit_req & spots[exit_req_slot] & ~r_pending[exit_req_slot];
    assign w_set_mask    = w_exit_accept ? (4'b0001 << exit_req_slot) : 4'b0000;

    // Lowest-index pending exit slot
    always_comb begin
        w_low_slot = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_low_slot = 2'(i);
            end
        end
    end

    // Next-state logic and arbitration (grants only leave IDLE)
    always_comb begin
        w_next_state  = r_state;
        w_grant_entry = 1'b0;
        w_grant_exit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_entry_elig && (!w_exit_elig || !r_last_entry)) begin
                    w_grant_entry = 1'b1;
                    w_next_state  = S_ISSUE;
                end else if (w_exit_elig) begin
                    w_grant_exit  = 1'b1;
                    w_next_state  = S_ISSUE;
                end
            end
            S_ISSUE: w_next_state = S_OPEN;
            S_OPEN: begin
                if (r_hold_cnt <= c_cnt_one) begin
                    w_next_state = S_CLOSE;
                end
            end
            S_CLOSE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Sensor copy for edge detection; tracks the lane even in reset so a car
    // parked on the sensor across reset is not granted a second time.
    always_ff @(posedge clk) begin
        r_entry_q <= entry_req;
    end

    // Registered outputs, request bookkeeping and hold counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            entry_signal  <= 1'b0;
            exit_signal   <= 1'b0;
            exit_slot     <= 2'd0;
            gate_open     <= 1'b0;
            busy          <= 1'b0;
            exit_err      <= 1'b0;
            r_entry_armed <= 1'b0;
            r_pending     <= 4'b0000;
            r_last_entry  <= 1'b0;
            r_hold_cnt    <= '0;
        end else begin
            entry_signal  <= w_grant_entry;
            exit_signal   <= w_grant_exit;
            if (w_grant_exit) begin
                exit_slot <= w_low_slot;
            end
            gate_open     <= (w_next_state == S_OPEN);
            busy          <= (w_next_state != S_IDLE);
            exit_err      <= exit_req & ~w_exit_accept;
            r_entry_armed <= w_entry_rise | (r_entry_armed & ~w_clr_entry);
            r_pending     <= (r_pending & ~w_clr_mask) | w_set_mask;
            if (r_state == S_ISSUE) begin
                r_last_entry <= entry_signal;
                r_hold_cnt   <= c_hold_load;
            end else if ((r_state == S_OPEN) && (r_hold_cnt != '0)) begin
                r_hold_cnt   <= r_hold_cnt - c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gate_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_scheduler
//  Description : Self-checking bench for gate_scheduler. A timeline model of
//                passages predicts every output each cycle; directed scenarios
//                add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_scheduler;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       entry_req;
    logic       exit_req;
    logic [1:0] exit_req_slot;
    logic [3:0] spots;
    logic       is_full;
    logic       entry_signal;
    logic       exit_signal;
    logic [1:0] exit_slot;
    logic       gate_open;
    logic       busy;
    logic       exit_err;

    gate_scheduler #(.HOLD_CYCLES(H)) dut (
        .clk           (clk),
        .reset         (reset),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .exit_req_slot (exit_req_slot),
        .spots         (spots),
        .is_full       (is_full),
        .entry_signal  (entry_signal),
        .exit_signal   (exit_signal),
        .exit_slot     (exit_slot),
        .gate_open     (gate_open),
        .busy          (busy),
        .exit_err      (exit_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Timeline model: a grant at edge g means ISSUE after edge g, gate
    // after edges g+1..g+H, busy after edges g..g+H+1, next grant no
    // earlier than edge g+H+3. The granted request retires at edge g+1.
    // ------------------------------------------------------------------
    int         n      = 0;
    int         m_g    = -1000;
    int         m_free = 0;
    bit         m_g_entry;
    logic [1:0] m_g_slot = 2'd0;
    bit         m_armed, m_last_entry, m_prev_entry;
    logic [3:0] m_pend;
    bit         e_entry, e_exit, e_gate, e_busy, e_err;
    logic [1:0] e_slot;

    // Advance the model on every rising edge using the inputs seen there
    always @(posedge clk) begin : model
        bit         rise, idle, el_en, el_ex, acc, clr_en;
        logic [3:0] clr;
        int         low;
        n = n + 1;
        if (!reset) begin
            m_g = -1000; m_free = n + 1; m_armed = 0; m_last_entry = 0;
            m_pend = 4'b0000; e_slot = 2'd0; e_err = 0;
        end else begin
            rise   = entry_req && !m_prev_entry;
            idle   = (n >= m_free);
            el_en  = (m_armed || rise) && !is_full;
            el_ex  = (m_pend != 4'b0000);
            low = 0;
            while (low < 4 && !m_pend[low]) low++;
            clr_en = 0;
            clr    = 4'b0000;
            if (n == m_g + 1) begin
                if (m_g_entry) clr_en = 1;
                else           clr[m_g_slot] = 1'b1;
                m_last_entry = m_g_entry;
            end
            acc   = exit_req && spots[exit_req_slot] && !m_pend[exit_req_slot];
            e_err = exit_req && !acc;
            if (idle && (el_en || el_ex)) begin
                m_g    = n;
                m_free = n + H + 3;
                if (el_en && (!el_ex || !m_last_entry)) begin
                    m_g_entry = 1;
                end else begin
                    m_g_entry = 0;
                    m_g_slot  = 2'(low);
                    e_slot    = 2'(low);
                end
            end
            m_pend = m_pend & ~clr;
            if (acc) m_pend[exit_req_slot] = 1'b1;
            m_armed = rise || (m_armed && !clr_en);
        end
        m_prev_entry = entry_req;
        e_entry = (n == m_g) && m_g_entry;
        e_exit  = (n == m_g) && !m_g_entry;
        e_gate  = (n >= m_g + 1) && (n <= m_g + H);
        e_busy  = (n >= m_g) && (n <= m_g + H + 1);
    end

    // Compare every output against the model between edges
    always @(negedge clk) begin
        if (chk_en) begin
            chk("entry_signal", {3'b0, entry_signal}, {3'b0, e_entry});
            chk("exit_signal",  {3'b0, exit_signal},  {3'b0, e_exit});
            chk("exit_slot",    {2'b0, exit_slot},    {2'b0, e_slot});
            chk("gate_open",    {3'b0, gate_open},    {3'b0, e_gate});
            chk("busy",         {3'b0, busy},         {3'b0, e_busy});
            chk("exit_err",     {3'b0, exit_err},     {3'b0, e_err});
        end
    end

    task automatic tick(input int cnt = 1);
        for (int i = 0; i < cnt; i++) @(negedge clk);
    endtask

    task automatic pulse_exit(input logic [1:0] slot);
        exit_req      = 1'b1;
        exit_req_slot = slot;
        tick();
        exit_req      = 1'b0;
    endtask

    task automatic lit(input string name, input logic act, input logic exp);
        chk(name, {3'b0, act}, {3'b0, exp});
    endtask

    // Directed scenarios
    initial begin
        reset = 1'b0; entry_req = 1'b1; exit_req = 1'b0; exit_req_slot = 2'd0;
        spots = 4'b1111; is_full = 1'b1;

        // Reset held with entry present and exit pulses
        for (int i = 0; i < 3; i++) begin
            exit_req      = (i != 1);
            exit_req_slot = 2'(i);
            tick();
            chk_en = 1'b1;
            lit("rst_busy", busy, 1'b0);
            lit("rst_gate", gate_open, 1'b0);
            lit("rst_err",  exit_err, 1'b0);
        end
        reset = 1'b1; exit_req = 1'b0; spots = 4'b0000; is_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("held_level_no_grant", entry_signal, 1'b0);
        end

        // Single entry
        entry_req = 1'b0; tick();
        entry_req = 1'b1; tick();
        lit("single_entry_pulse", entry_signal, 1'b1);
        lit("single_busy_issue",  busy,         1'b1);
        lit("single_gate_issue",  gate_open,    1'b0);
        for (int i = 0; i < H; i++) begin
            tick();
            lit("single_gate_open", gate_open, 1'b1);
        end
        tick();
        lit("single_close_gate", gate_open, 1'b0);
        lit("single_close_busy", busy,      1'b1);
        tick();
        lit("single_idle_busy",  busy,      1'b0);
        entry_req = 1'b0;

        // Full lot handoff
        spots = 4'b1111; is_full = 1'b1; tick();
        entry_req = 1'b1;
        tick(3);
        lit("full_no_grant", busy, 1'b0);
        pulse_exit(2'd2);
        tick();
        lit("full_exit_pulse", exit_signal, 1'b1);
        chk("full_exit_slot", {2'b0, exit_slot}, 4'd2);
        spots = 4'b1011; is_full = 1'b0;
        tick(H + 3);
        lit("full_entry_after", entry_signal, 1'b1);
        spots = 4'b0000;
        tick(H + 3);
        entry_req = 1'b0;

        // Tie fairness from a fresh reset (last grant = exit)
        reset = 1'b0; tick(); reset = 1'b1;
        spots = 4'b0010;
        pulse_exit(2'd1);
        entry_req = 1'b1; tick();
        lit("tie1_entry_first", entry_signal, 1'b1);
        entry_req = 1'b0; tick();
        entry_req = 1'b1; tick();
        tick(H + 1);
        lit("tie2_exit_first", exit_signal, 1'b1);
        chk("tie2_exit_slot", {2'b0, exit_slot}, 4'd1);
        tick(H + 3);
        lit("tie2_entry_second", entry_signal, 1'b1);
        tick(H + 3);

        // Exit queue order and errors
        entry_req = 1'b0; spots = 4'b1001; tick();
        entry_req = 1'b1; tick();
        lit("q_entry", entry_signal, 1'b1);
        tick();
        pulse_exit(2'd3);
        pulse_exit(2'd0);
        pulse_exit(2'd3);
        lit("q_dup_err", exit_err, 1'b1);
        tick(3);
        lit("q_first_exit", exit_signal, 1'b1);
        chk("q_first_slot", {2'b0, exit_slot}, 4'd0);
        tick(H + 3);
        lit("q_second_exit", exit_signal, 1'b1);
        chk("q_second_slot", {2'b0, exit_slot}, 4'd3);
        tick(H + 3);
        pulse_exit(2'd1);
        lit("empty_slot_err", exit_err, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            lit("empty_slot_no_service", busy, 1'b0);
        end

        // Reset during OPEN with an exit pending
        entry_req = 1'b0; tick();
        entry_req = 1'b1; tick();
        lit("rmid_entry", entry_signal, 1'b1);
        pulse_exit(2'd0);
        tick();
        lit("rmid_gate_before", gate_open, 1'b1);
        reset = 1'b0; tick();
        lit("rmid_gate_low", gate_open, 1'b0);
        lit("rmid_idle",     busy,      1'b0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            lit("rmid_no_exit", exit_signal, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gate_scheduler.md
# gate_scheduler

Shares the single parking gate between the entry lane and exit requests. It sequences each passage: grant, one-cycle event pulse to the parking `FSM`, gate hold, close. It sits between the lane sensors and the `FSM`, whose `entry_signal`/`exit_signal`/`exit_slot` inputs it drives. It uses the `FSM`'s `spots` and `is_full` to qualify requests.

## Interface
- `HOLD_CYCLES`, default 4: cycles `gate_open` stays high per passage, minimum 1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `entry_req` in 1: entry-lane car-present sensor, level.
- `exit_req` in 1: exit request, one-cycle pulse.
- `exit_req_slot` in 2: slot of the exiting car, valid with `exit_req`.
- `spots` in 4: occupancy from the `FSM`; bit i set means slot i is occupied.
- `is_full` in 1: lot-full flag from the `FSM`.
- `entry_signal` out 1: one-cycle entry event to the `FSM`.
- `exit_signal` out 1: one-cycle exit event to the `FSM`.
- `exit_slot` out 2: slot for `exit_signal`; holds its last value otherwise.
- `gate_open` out 1: physical gate drive.
- `busy` out 1: state is not IDLE.
- `exit_err` out 1: one-cycle pulse when an exit request is rejected.

## Operation
- **Entry arming**
  - A rising edge of `entry_req` (versus a registered copy) sets `entry_armed`.
  - An armed entry is cleared only when granted.
  - A held level never produces a second grant.
- **Exit queue**
  - Exit requests go into a 4-bit `pending` bitmap.
  - `exit_req` with `spots[exit_req_slot]`=1 and the bit not pending sets the bit.
  - Otherwise the request is dropped and `exit_err` pulses the next cycle.
- **Eligibility**
  - Entry is eligible when `entry_armed` (or the edge occurs this cycle) and `is_full`=0.
  - Exit is eligible when `pending` is nonzero.
  - Among pending exits, the lowest slot index wins.
- **Arbitration (IDLE only)**
  - If only one side is eligible, it wins.
  - If both are eligible, the side opposite `last_grant` wins.
  - `last_grant` resets to exit, so the first tie goes to entry.
- **States**
  - IDLE: a grant moves to ISSUE; no grant stays in IDLE.
  - ISSUE (1 cycle): pulse `entry_signal`, or `exit_signal` with `exit_slot`=granted slot. Clear the granted `pending` bit or `entry_armed`. Update `last_grant`. Load the hold counter. Go to OPEN.
  - OPEN: `gate_open`=1 for exactly `HOLD_CYCLES` cycles, then go to CLOSE.
  - CLOSE (1 cycle): gate low, guard cycle, then go to IDLE.
- Requests arriving in any state are queued or armed. They are served only from IDLE.
- **Boundary rules**
  - Full lot: an armed entry waits. After an exit pulse, the `FSM` drops `is_full`, and the entry becomes eligible at the next IDLE.
  - `exit_req` for the slot being cleared in the same ISSUE cycle is rejected with `exit_err`.
  - `exit_req` and grant-clear of a different slot in the same cycle: both take effect.
  - Reset mid-operation: every output and all state return to reset values on the next edge. `pending` and `entry_armed` are discarded.
- Hold counter width is `$clog2(HOLD_CYCLES+1)`. It counts down and does not wrap.

## Timing
- Reset values:
  - State IDLE.
  - `entry_signal`, `exit_signal`, `gate_open`, `busy`, `exit_err` = 0.
  - `exit_slot`=0, `pending`=0, `entry_armed`=0, `last_grant`=exit.
- All outputs are registered.
- A request eligible at edge k with state IDLE gives `entry_signal`/`exit_signal` high during cycle k+1 (ISSUE).
- `gate_open` is high during cycles k+2 through k+1+`HOLD_CYCLES`.
- CLOSE falls in cycle k+2+`HOLD_CYCLES`.
- The earliest next ISSUE is cycle k+4+`HOLD_CYCLES`.
- Passage period is `HOLD_CYCLES`+3 cycles under continuous load.
- `busy` is high in ISSUE, OPEN and CLOSE.
- `exit_err` is high for exactly the cycle after the rejected request edge.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `entry_req`=1 and `exit_req` pulsing. Expect all outputs 0 and no pulses. After release with `entry_req` held at 1, expect no entry grant until `entry_req` falls and rises again.
- **Single entry:** `spots`=0000, `HOLD_CYCLES`=4, rising `entry_req` at edge k. Expect `entry_signal` 1 only in cycle k+1, `gate_open` 1 in k+2..k+5, `busy` low again at k+7.
- **Full lot handoff:** `spots`=1111, `is_full`=1, entry armed (expect no grant). Pulse `exit_req` slot 2. Expect `exit_signal` with `exit_slot`=2. The model `FSM` drops `is_full`; expect `entry_signal` in the next ISSUE.
- **Tie fairness:** `is_full`=0, entry armed and slot 1 pending at the same IDLE. Expect order entry, then exit. Re-create the tie: expect exit first.
- **Exit queue order/errors:**
  - During OPEN, pulse `exit_req` for slots 3, 0 and 3 again. Expect the second slot-3 request to raise `exit_err`, then service of slot 0 then slot 3.
  - `exit_req` for slot 1 with `spots[1]`=0: expect `exit_err` and no service.
- **Reset mid-OPEN:** assert `reset` during cycle k+3 with an exit pending. Expect `gate_open`=0 and IDLE on the next edge. After release, expect no exit pulse.
